// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: one stream with full sideband, master/slave views.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                    input  tready);
    modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                    output tready);
endinterface

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter: REQ_NUM AXI4-Stream inputs share one
// registered output; an owner keeps the grant from its first beat to tlast.
module axi4_stream_pkt_arbiter #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int REQ_NUM     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4_stream_if.slave         pkt_i [REQ_NUM],
    axi4_stream_if.master        pkt_o,
    output logic [REQ_NUM-1:0]   grant_o,
    output logic                 busy_o
);
    localparam int KW    = TDATA_WIDTH / 8;
    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [KW-1:0]          tkeep;
        logic [KW-1:0]          tstrb;
        logic                   tlast;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
        logic [TUSER_WIDTH-1:0] tuser;
    } beat_t;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;     // last winner == current owner while LOCKED
    logic [REQ_NUM-1:0]      grant_q, grant_d;
    logic                    tvalid_q;
    beat_t                   out_q;

    logic [REQ_NUM-1:0]      vld_w;
    logic [REQ_NUM-1:0]      rdy_w;
    beat_t [REQ_NUM-1:0]     beat_w;
    logic [IDX_W-1:0]        win_w;
    logic                    found_w;
    logic                    out_free_w;
    logic                    rx_hs_w;
    logic                    tx_hs_w;

    // Flatten the interface array into packed per-lane vectors.
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_lane
        assign vld_w[k]        = pkt_i[k].tvalid;
        assign beat_w[k].tdata = pkt_i[k].tdata;
        assign beat_w[k].tkeep = pkt_i[k].tkeep;
        assign beat_w[k].tstrb = pkt_i[k].tstrb;
        assign beat_w[k].tlast = pkt_i[k].tlast;
        assign beat_w[k].tid   = pkt_i[k].tid;
        assign beat_w[k].tdest = pkt_i[k].tdest;
        assign beat_w[k].tuser = pkt_i[k].tuser;
        assign pkt_i[k].tready = rdy_w[k];
    end

    // The output slot can take a beat when empty or draining this cycle.
    assign out_free_w = !tvalid_q || pkt_o.tready;
    assign rx_hs_w    = (state_q == LOCKED) && vld_w[ptr_q] && out_free_w;
    assign tx_hs_w    = tvalid_q && pkt_o.tready;

    // Round-robin pick: first valid requester after the previous winner.
    always_comb begin
        win_w   = ptr_q;
        found_w = 1'b0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            if (!found_w && vld_w[IDX_W'((int'(ptr_q) + i) % REQ_NUM)]) begin
                found_w = 1'b1;
                win_w   = IDX_W'((int'(ptr_q) + i) % REQ_NUM);
            end
        end
    end

    // Next state, grant and per-lane tready; only the owner ever sees tready.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rdy_w   = '0;
        case (state_q)
            IDLE: begin
                if (found_w) begin
                    state_d = LOCKED;
                    ptr_d   = win_w;
                    grant_d = REQ_NUM'(1) << win_w;
                end
            end
            LOCKED: begin
                rdy_w[ptr_q] = out_free_w;
                if (rx_hs_w && beat_w[ptr_q].tlast) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(REQ_NUM - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Single output register stage: load on rx, empty on tx without refill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tvalid_q <= 1'b0;
            out_q    <= '0;
        end else if (rx_hs_w) begin
            tvalid_q <= 1'b1;
            out_q    <= beat_w[ptr_q];
        end else if (tx_hs_w) begin
            tvalid_q <= 1'b0;
        end
    end

    assign pkt_o.tvalid = tvalid_q;
    assign pkt_o.tdata  = out_q.tdata;
    assign pkt_o.tkeep  = out_q.tkeep;
    assign pkt_o.tstrb  = out_q.tstrb;
    assign pkt_o.tlast  = out_q.tlast;
    assign pkt_o.tid    = out_q.tid;
    assign pkt_o.tdest  = out_q.tdest;
    assign pkt_o.tuser  = out_q.tuser;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == LOCKED);
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for axi4_stream_pkt_arbiter: queue-driven requesters,
// an output beat log, and hand-computed expectations at each negedge.
module tb_axi4_stream_pkt_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        last;
        logic        id;
        logic        dest;
        logic        user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(32)) in_if [N] ();
    axi4_stream_if #(.TDATA_WIDTH(32)) out_if ();
    logic [N-1:0] grant;
    logic         busy;

    axi4_stream_pkt_arbiter #(.TDATA_WIDTH(32), .TID_WIDTH(1), .TDEST_WIDTH(1),
                              .TUSER_WIDTH(1), .REQ_NUM(N)) dut (
        .clk_i(clk), .rst_i(rst), .pkt_i(in_if), .pkt_o(out_if),
        .grant_o(grant), .busy_o(busy));

    // Requester scripts: initial writes sb/wr/en/flush, driver owns rd.
    beat_t        sb [N][64];
    int           wr [N];
    int           rd [N];
    logic [N-1:0] en    = '1;
    logic [N-1:0] flush = '0;
    logic [N-1:0] in_vld, in_rdy, hs;
    logic         out_rdy = 1'b1;

    for (genvar k = 0; k < N; k++) begin : g_drv
        assign in_vld[k]       = en[k] && (rd[k] != wr[k]);
        assign in_if[k].tvalid = in_vld[k];
        assign in_if[k].tdata  = sb[k][rd[k] % 64].data;
        assign in_if[k].tkeep  = sb[k][rd[k] % 64].keep;
        assign in_if[k].tstrb  = sb[k][rd[k] % 64].strb;
        assign in_if[k].tlast  = sb[k][rd[k] % 64].last;
        assign in_if[k].tid    = sb[k][rd[k] % 64].id;
        assign in_if[k].tdest  = sb[k][rd[k] % 64].dest;
        assign in_if[k].tuser  = sb[k][rd[k] % 64].user;
        assign in_rdy[k]       = in_if[k].tready;
    end
    assign out_if.tready = out_rdy;

    initial for (int k = 0; k < N; k++) rd[k] = 0;

    // Advance each script head after its handshake edge.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) hs[k] = in_vld[k] && in_rdy[k];
        #1;
        for (int k = 0; k < N; k++)
            if (flush[k]) rd[k] = wr[k];
            else if (hs[k]) rd[k] = rd[k] + 1;
    end

    // Log every beat leaving the output.
    beat_t mon [256];
    int    mon_n = 0;
    always @(posedge clk) begin
        if (!rst && out_if.tvalid && out_rdy) begin
            mon[mon_n % 256] <= '{out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast,
                                  out_if.tid, out_if.tdest, out_if.tuser};
            mon_n <= mon_n + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input int k, input logic [31:0] d, input logic last,
                        input logic [3:0] keep = 4'hF, input logic id = 1'b0,
                        input logic dest = 1'b0, input logic user = 1'b0);
        sb[k][wr[k] % 64] = '{d, keep, keep, last, id, dest, user};
        wr[k]++;
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    int    base;
    int    i;
    logic [31:0] held;

    initial begin
        for (int k = 0; k < N; k++) wr[k] = 0;
        step(2);
        // Reset state
        chk("rst_tvalid", out_if.tvalid, 0);
        chk("rst_tdata", out_if.tdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tready", in_rdy, 0);
        rst = 1'b0;
        step();

        // Single requester: 3-beat packet on lane 2
        base = mon_n;
        push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
        chk("t1_idle_rdy", in_rdy, 0);
        step();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_busy", busy, 1);
        chk("t1_rdy", in_rdy, 4'b0100);
        step();
        chk("t1_d0", {out_if.tvalid, out_if.tlast, out_if.tdata}, {2'b10, 32'hA0});
        step();
        chk("t1_d1", {out_if.tvalid, out_if.tlast, out_if.tdata}, {2'b10, 32'hA1});
        step();
        chk("t1_d2", {out_if.tvalid, out_if.tlast, out_if.tdata}, {2'b11, 32'hA2});
        chk("t1_gnt_off", grant, 0);
        chk("t1_busy_off", busy, 0);
        step();
        chk("t1_drain", out_if.tvalid, 0);
        chk("t1_cnt", mon_n - base, 3);

        // Fairness from a fresh pointer: all lanes offer two 2-beat packets
        rst = 1'b1; step(); rst = 1'b0; step();
        base = mon_n;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++) begin
                push(k, 32'(k * 16 + p * 2), 0);
                push(k, 32'(k * 16 + p * 2 + 1), 1);
            end
        i = 0;
        while (mon_n - base < 16 && i < 60) begin step(); i++; end
        chk("fair_cnt", mon_n - base, 16);
        for (int b = 0; b < 16; b++)
            chk($sformatf("fair_b%0d", b), {mon[(base + b) % 256].last, mon[(base + b) % 256].data},
                {1'(b % 2), 32'(((b / 2) % 4) * 16 + (b / 8) * 2 + (b % 2))});
        step(2);

        // Backpressure: pointer now 3, so lane 0 wins
        base = mon_n;
        push(0, 32'h10, 0); push(0, 32'h11, 0); push(0, 32'h12, 0); push(0, 32'h13, 1);
        step();
        chk("bp_grant", grant, 4'b0001);
        step();
        chk("bp_d0", out_if.tdata, 32'h10);
        out_rdy = 1'b0;
        #1 chk("bp_rdy_low", in_rdy, 0);
        held = out_if.tdata;
        step();
        chk("bp_hold1", out_if.tdata, held);
        chk("bp_hold1_v", out_if.tvalid, 1);
        step();
        chk("bp_hold2", out_if.tdata, held);
        out_rdy = 1'b1;
        #1 chk("bp_rdy_back", in_rdy, 4'b0001);
        step(5);
        chk("bp_cnt", mon_n - base, 4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("bp_b%0d", b), mon[(base + b) % 256].data, 32'(32'h10 + b));

        // Mid-packet stall: pointer 0, lane 1 wins over lane 3
        base = mon_n;
        push(1, 32'h20, 0); push(1, 32'h21, 0); push(1, 32'h22, 0); push(1, 32'h23, 1);
        push(3, 32'h30, 1);
        step();
        chk("st_grant", grant, 4'b0010);
        step(2);
        chk("st_d1", out_if.tdata, 32'h21);
        en[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("st_hold_g%0d", c), grant, 4'b0010);
            chk($sformatf("st_hold_r%0d", c), in_rdy[3], 0);
            step();
        end
        en[1] = 1'b1;
        step();
        chk("st_d2", out_if.tdata, 32'h22);
        step();
        chk("st_gnt_off", grant, 0);
        step();
        chk("st_grant3", grant, 4'b1000);
        step(3);
        chk("st_cnt", mon_n - base, 5);
        for (int b = 0; b < 4; b++)
            chk($sformatf("st_b%0d", b), mon[(base + b) % 256].data, 32'(32'h20 + b));
        chk("st_b4", mon[(base + 4) % 256].data, 32'h30);

        // Reset mid-packet: pointer 3, lane 2 is the only requester
        push(2, 32'h40, 0); push(2, 32'h41, 0); push(2, 32'h42, 0); push(2, 32'h43, 1);
        step(3);
        chk("rm_beat2", out_if.tdata, 32'h41);
        rst = 1'b1; flush = '1;
        #1;
        chk("rm_tvalid", out_if.tvalid, 0);
        chk("rm_grant", grant, 0);
        chk("rm_busy", busy, 0);
        step(2);
        rst = 1'b0; flush = '0;
        step();
        base = mon_n;
        push(0, 32'h50, 1); push(3, 32'h53, 1);
        step();
        chk("rm_first0", grant, 4'b0001);
        step(2);
        chk("rm_then3", grant, 4'b1000);
        step(3);
        chk("rm_cnt", mon_n - base, 2);
        chk("rm_o0", mon[base % 256].data, 32'h50);
        chk("rm_o1", mon[(base + 1) % 256].data, 32'h53);

        // Field passthrough on a single-beat packet (pointer 3, lane 1)
        push(1, 32'hCAFE_0001, 1, 4'b0011, 1, 1, 1);
        chk("fp_busy0", busy, 0);
        step();
        chk("fp_busy1", busy, 1);
        step();
        chk("fp_busy2", busy, 0);
        chk("fp_fields", {out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tstrb,
                          out_if.tlast, out_if.tid, out_if.tdest, out_if.tuser},
            {1'b1, 32'hCAFE_0001, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1});
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
